// File: rtl/lab_decoder_scan_n_pkg.sv
// Package lab_decoder_pkg: shared types and helpers for the lab_decoder_scan_n
// slice.
//   mode_e    : MODE_DIRECT (1'b0) / MODE_SCAN (1'b1)
//   onehot    : one-hot code of idx in a MAX_OUT_W-wide vector. Callers
//               truncate the result to their own width. Bits at or above
//               width are always 0.
//   out_pol   : applies the output polarity. Inverts when the build defines
//               DECODER_ACTIVE_LOW_EN (common-anode digit enables).
package lab_decoder_pkg;

  localparam int unsigned MAX_OUT_W = 256;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  function automatic logic [MAX_OUT_W-1:0] onehot(input int unsigned idx,
                                                  input int unsigned width);
    logic [MAX_OUT_W-1:0] r;
    r = '0;
    if (idx < width) r = MAX_OUT_W'(1) << idx;
    return r;
  endfunction

  function automatic logic [MAX_OUT_W-1:0] out_pol(input logic [MAX_OUT_W-1:0] v);
`ifdef DECODER_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

endpackage

// File: rtl/lab_decoder_scan_n_if.sv
// lab_decoder_scan_n_if: control and decode bus of lab_decoder_scan_n.
//   en   : 1 = decode active, 0 = outputs inactive and state held
//   mode : 0 = direct, 1 = scan
//   sel  : SEL_W-bit select used in direct mode
//   out  : OUT_W registered one-hot decode of idx
//   idx  : SEL_W registered index currently decoded
//   wrap : one-cycle pulse when the scan index wraps LAST -> 0
// The master modport drives en/mode/sel. The slave modport (the decoder)
// drives out/idx/wrap.
interface lab_decoder_scan_n_if #(
  parameter int unsigned SEL_W = 4
);
  localparam int unsigned OUT_W = 1 << SEL_W;

  logic             en;
  logic             mode;
  logic [SEL_W-1:0] sel;
  logic [OUT_W-1:0] out;
  logic [SEL_W-1:0] idx;
  logic             wrap;

  modport master (output en, mode, sel, input out, idx, wrap);
  modport slave  (input en, mode, sel, output out, idx, wrap);
endinterface

// File: rtl/lab_decoder_scan_n_tick_gen.sv
// lab_tick_gen: scan step prescaler.
//   clk   : rising-edge clock
//   rst_n : synchronous reset, active low (counter -> 0)
//   run   : count this cycle
//   clr   : force counter to 0 (takes priority over run)
//   tick  : high on the run cycle where the counter is at DIV-1.
//           The counter returns to 0 on that edge.
module lab_tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic tick
);
  localparam int unsigned CW = $clog2(DIV + 1);

  logic [CW-1:0] cnt;

  assign tick = run && (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (run) cnt <= tick ? '0 : cnt + CW'(1);
  end
endmodule

// File: rtl/lab_decoder_scan_n.sv
// lab_decoder_scan_n: registered N-to-2^N one-hot decoder with two modes.
// In direct mode it decodes sel. In scan mode it decodes an internal index
// that advances every DIV clocks and wraps after LAST.
//   clk   : rising-edge clock
//   rst_n : synchronous reset, active low
//   bus   : lab_decoder_scan_n_if slave (en, mode, sel -> out, idx, wrap)
// Parameters: SEL_W (select width, OUT_W = 1<<SEL_W), DIV (>= 1),
//   LAST (0..OUT_W-1, highest scan index).
// Build option: DECODER_ACTIVE_LOW_EN inverts out. The inactive value is
//   then all ones. idx and wrap are unaffected.
module lab_decoder_scan_n
  import lab_decoder_pkg::*;
#(
  parameter int unsigned SEL_W = 4,
  parameter int unsigned DIV   = 4,
  parameter int unsigned LAST  = (1 << SEL_W) - 1
) (
  input logic                 clk,
  input logic                 rst_n,
  lab_decoder_scan_n_if.slave bus
);
  localparam int unsigned OUT_W = 1 << SEL_W;
  localparam logic [OUT_W-1:0] OUT_IDLE = OUT_W'(out_pol('0));

  mode_e            mode_q, mode_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;
  logic             scan_run, tick_clr, tick;

  // Scan runs only once scan mode was already registered.
  // Every other enabled cycle (direct, or scan entry) holds the prescaler at 0.
  assign scan_run = bus.en && (bus.mode == MODE_SCAN) && (mode_q == MODE_SCAN);
  assign tick_clr = bus.en && !scan_run;

  lab_tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (scan_run),
    .clr   (tick_clr),
    .tick  (tick)
  );

  always_comb begin
    mode_d = mode_q;
    idx_d  = idx_q;
    wrap_d = 1'b0;
    out_d  = OUT_IDLE;
    if (bus.en) begin
      mode_d = mode_e'(bus.mode);
      if (bus.mode == MODE_DIRECT) begin
        idx_d = bus.sel;
      end else if (mode_q == MODE_DIRECT) begin
        idx_d = '0;
      end else if (tick) begin
        // Compare against LAST before incrementing, so idx never overflows.
        if (idx_q == SEL_W'(LAST)) begin
          idx_d  = '0;
          wrap_d = 1'b1;
        end else begin
          idx_d = idx_q + SEL_W'(1);
        end
      end
      // Decode the next index, so out and idx land on the same edge.
      out_d = OUT_W'(out_pol(onehot(32'(idx_d), OUT_W)));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q <= MODE_DIRECT;
      idx_q  <= '0;
      out_q  <= OUT_IDLE;
      wrap_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      idx_q  <= idx_d;
      out_q  <= out_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.idx  = idx_q;
  assign bus.wrap = wrap_q;
endmodule
